// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Program-counter controller for a combinational instruction memory.
// The block holds the PC register. It launches a program on `start` and
// then advances or redirects the PC on every unstalled cycle. It stops
// when the word fetched at the current PC is the halt encoding.
//
// Optional feature macro: FETCH_CYCLE_COUNT_EN
//   defined     - cycle_count counts consumed instructions (saturating,
//                 cleared on launch).
//   not defined - no counter is built and cycle_count reads 0.
//
// Parameters:
//   PC_BITS    - PC and branch-target width (must match the memory depth)
//   HALT_WORD  - 9-bit instruction encoding that ends a program
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   start          in   launch request, honoured in IDLE or DONE only
//   start_pc       in   first instruction address loaded on launch
//   stall          in   freezes PC and state for the current cycle
//   branch_taken   in   redirect request for the current instruction
//   branch_target  in   absolute redirect address
//   instr          in   memory word currently read at pc
//   pc             out  registered fetch address
//   running        out  high while a program executes
//   fetch_valid    out  running & ~stall: instr is consumed this cycle
//   done           out  high after a halt word was consumed
//   pc_wrap        out  sticky flag, set when pc increments past all-ones
//   cycle_count    out  consumed-instruction count (0 when not built)

module fetch_sequencer #(
    parameter int          PC_BITS   = 12,
    parameter logic [8:0]  HALT_WORD = 9'b111_111_111
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [PC_BITS-1:0] start_pc,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_BITS-1:0] branch_target,
    input  logic [8:0]         instr,
    output logic [PC_BITS-1:0] pc,
    output logic               running,
    output logic               fetch_valid,
    output logic               done,
    output logic               pc_wrap,
    output logic [15:0]        cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_BITS-1:0] pc_reg, pc_next;
    logic               wrap_reg, wrap_next;

    // A word is consumed on every RUN cycle that is not stalled.
    logic consume;
    assign consume = (state_reg == S_RUN) && !stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            wrap_reg  <= wrap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        wrap_next  = wrap_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    pc_next    = start_pc;
                    wrap_next  = 1'b0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    // The halt word wins over a branch so that the PC
                    // is left pointing at the halt instruction.
                    if (instr == HALT_WORD) begin
                        state_next = S_DONE;
                    end else if (branch_taken) begin
                        pc_next = branch_target;
                    end else begin
                        pc_next = pc_reg + PC_BITS'(1);
                        if (&pc_reg) begin
                            wrap_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pc          = pc_reg;
    assign running     = (state_reg == S_RUN);
    assign done        = (state_reg == S_DONE);
    assign pc_wrap     = wrap_reg;
    assign fetch_valid = consume;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] count_reg;
    logic        launch;

    assign launch = start && (state_reg != S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (launch) begin
            count_reg <= '0;
        end else if (consume && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign cycle_count = count_reg;
`else
    assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized
// programs. A behavioural model decides the expected outputs, and a
// negedge compare process checks the DUT against that model.
module tb_fetch_sequencer;

    localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] start_pc;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic [8:0]  instr;
    logic [11:0] pc;
    logic        running;
    logic        fetch_valid;
    logic        done;
    logic        pc_wrap;
    logic [15:0] cycle_count;

    logic [8:0] mem [0:4095];
    assign instr = mem[pc];

    fetch_sequencer #(.PC_BITS(12), .HALT_WORD(HALT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .start_pc      (start_pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .pc            (pc),
        .running       (running),
        .fetch_valid   (fetch_valid),
        .done          (done),
        .pc_wrap       (pc_wrap),
        .cycle_count   (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program status, PC and counters held as plain integers.
    bit m_running = 1'b0;
    bit m_done    = 1'b0;
    bit m_wrap    = 1'b0;
    int m_pc      = 0;
    int m_count   = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_running = 1'b0;
            m_done    = 1'b0;
            m_wrap    = 1'b0;
            m_pc      = 0;
            m_count   = 0;
        end else if (m_running) begin
            if (!stall) begin
                m_count = (m_count < 65535) ? m_count + 1 : 65535;
                if (mem[m_pc] == HALT) begin
                    m_running = 1'b0;
                    m_done    = 1'b1;
                end else if (branch_taken) begin
                    m_pc = int'(branch_target);
                end else begin
                    if (m_pc == 4095) m_wrap = 1'b1;
                    m_pc = (m_pc + 1) % 4096;
                end
            end
        end else if (start) begin
            m_running = 1'b1;
            m_done    = 1'b0;
            m_pc      = int'(start_pc);
            m_wrap    = 1'b0;
            m_count   = 0;
        end
    end

    always @(negedge clk) begin
        chk("pc",          32'(pc),          32'(m_pc));
        chk("running",     32'(running),     32'(m_running));
        chk("done",        32'(done),        32'(m_done));
        chk("fetch_valid", 32'(fetch_valid), 32'(m_running & ~stall));
        chk("pc_wrap",     32'(pc_wrap),     32'(m_wrap));
        chk("cycle_count", 32'(cycle_count), CNT_EN ? 32'(m_count) : 32'd0);
    end

    task automatic fill_nonhalt();
        for (int i = 0; i < 4096; i++) mem[i] = 9'($urandom_range(0, 510));
    endtask

    task automatic fill_random(input int halt_pct);
        for (int i = 0; i < 4096; i++)
            mem[i] = ($urandom_range(0, 99) < halt_pct) ? HALT : 9'($urandom_range(0, 510));
    endtask

    // Returns one time unit after the edge that samples start.
    task automatic launch(input logic [11:0] a);
        @(posedge clk); #1;
        start = 1'b1;
        start_pc = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    int s2_exp [4] = '{0, 1, 2, 256};

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        start_pc = '0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        fill_nonhalt();
        #22 reset_n = 1'b1;

        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);

        // 1: straight line program, halt at 5
        $display("scenario 1: start_pc=0, halt at 5");
        fill_nonhalt();
        mem[5] = HALT;
        launch(12'h000);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("s1_pc", 32'(pc), 32'(k));
            chk("s1_running", 32'(running), 32'd1);
        end
        @(negedge clk);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_pc_hold", 32'(pc), 32'd5);
        chk("s1_count", 32'(cycle_count), CNT_EN ? 32'd6 : 32'd0);

        // 2: branch at pc=2 to 0x100 where the halt sits
        $display("scenario 2: branch at pc=2 to 0x100");
        fill_nonhalt();
        mem[12'h100] = HALT;
        branch_target = 12'h100;
        launch(12'h000);
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 2);
            @(negedge clk);
            chk("s2_pc", 32'(pc), 32'(s2_exp[i]));
            @(posedge clk); #1;
        end
        branch_taken = 1'b0;
        @(negedge clk);
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_pc_hold", 32'(pc), 32'h100);

        // 3: stall three cycles at pc=3 with a pending branch
        $display("scenario 3: stall x3 at pc=3 with branch to 0x020");
        fill_nonhalt();
        mem[12'h020] = HALT;
        branch_target = 12'h020;
        launch(12'h000);
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_stall_pc", 32'(pc), 32'd3);
            chk("s3_stall_fv", 32'(fetch_valid), 32'd0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        chk("s3_release_pc", 32'(pc), 32'd3);
        chk("s3_release_fv", 32'(fetch_valid), 32'd1);
        @(posedge clk); #1;
        branch_taken = 1'b0;
        @(negedge clk);
        chk("s3_branch_pc", 32'(pc), 32'h020);
        @(negedge clk);
        chk("s3_done", 32'(done), 32'd1);

        // 4: wrap from 0xFFF to 0
        $display("scenario 4: start_pc=0xFFF, wrap to 0, halt at 1");
        fill_nonhalt();
        mem[1] = HALT;
        launch(12'hFFF);
        @(negedge clk);
        chk("s4_pc_fff", 32'(pc), 32'hFFF);
        chk("s4_wrap0", 32'(pc_wrap), 32'd0);
        @(negedge clk);
        chk("s4_pc_0", 32'(pc), 32'd0);
        chk("s4_wrap1", 32'(pc_wrap), 32'd1);
        chk("s4_running", 32'(running), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_wrap_hold", 32'(pc_wrap), 32'd1);
        chk("s4_count", 32'(cycle_count), CNT_EN ? 32'd3 : 32'd0);

        // 5: halt with simultaneous branch, then relaunch at 7
        $display("scenario 5: halt+branch at 0x040, relaunch at 7");
        mem[12'h040] = HALT;
        branch_target = 12'h080;
        launch(12'h040);
        branch_taken = 1'b1;
        @(negedge clk);
        chk("s5_pc", 32'(pc), 32'h040);
        chk("s5_wrap_clr", 32'(pc_wrap), 32'd0);
        @(negedge clk);
        chk("s5_done", 32'(done), 32'd1);
        chk("s5_no_redirect", 32'(pc), 32'h040);
        branch_taken = 1'b0;
        fill_nonhalt();
        mem[8] = HALT;
        launch(12'h007);
        @(negedge clk);
        chk("s5_relaunch_pc", 32'(pc), 32'd7);
        chk("s5_relaunch_done", 32'(done), 32'd0);
        chk("s5_relaunch_count", 32'(cycle_count), 32'd0);
        start = 1'b1;
        start_pc = 12'h300;
        @(negedge clk);
        chk("s5_start_ignored", 32'(pc), 32'd8);
        start = 1'b0;
        @(negedge clk);
        chk("s5_done2", 32'(done), 32'd1);

        // 6: asynchronous reset mid-run at pc=9
        $display("scenario 6: async reset mid-run at pc=9");
        fill_nonhalt();
        launch(12'h009);
        #2 reset_n = 1'b0;
        #1;
        chk("s6_pc", 32'(pc), 32'd0);
        chk("s6_running", 32'(running), 32'd0);
        chk("s6_fv", 32'(fetch_valid), 32'd0);
        chk("s6_done", 32'(done), 32'd0);
        chk("s6_wrap", 32'(pc_wrap), 32'd0);
        chk("s6_count", 32'(cycle_count), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("s6_idle", 32'(running), 32'd0);
        end

        // Randomized programs, checked by the compare process.
        for (int p = 0; p < 30; p++) begin
            fill_random(5);
            @(posedge clk); #1;
            start = 1'b1;
            start_pc = (p % 4 == 0) ? 12'($urandom_range(4088, 4095)) : 12'($urandom);
            $display("program %0d: start_pc=%03h", p, start_pc);
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #1;
                start         = ($urandom_range(0, 19) == 0);
                start_pc      = 12'($urandom);
                stall         = ($urandom_range(0, 3) == 0);
                branch_taken  = ($urandom_range(0, 6) == 0);
                branch_target = 12'($urandom);
                if ($urandom_range(0, 299) == 0) begin
                    #2 reset_n = 1'b0;
                    #3 reset_n = 1'b1;
                end
            end
            stall = 1'b0;
            branch_taken = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
